// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM state encoding
// and the one-hot result codes.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] CMP_EQ = 3'b001;
  localparam logic [2:0] CMP_GT = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b100;

endpackage

// File: rtl/chunk_compare.sv
// Combinational unsigned compare of one CHUNK-bit slice: XNOR equality plus
// an MSB-first priority network for greater/lesser.
module chunk_compare #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  always_comb begin
    eq = &(a ~^ b);
    gt = 1'b0;
    lt = 1'b0;
    // The highest differing bit decides; lower bits are masked once it is found.
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (!gt && !lt) begin
        if (a[i] && !b[i]) gt = 1'b1;
        else if (!a[i] && b[i]) lt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per cycle MSB first,
// with early exit. Optional two's-complement mode under COMPARATOR_SIGNED_EN.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int CHUNK  = 4,
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK,
  localparam int CUW    = $clog2(NCHUNK) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] bit1,
  input  logic [WIDTH-1:0] bit2,
`ifdef COMPARATOR_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       final_answer,
  output logic [CUW-1:0]   chunks_used
);

  localparam int PW   = NCHUNK * CHUNK;
  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t            state, state_nxt;
  logic [IDXW-1:0]   idx;
  logic [PW-1:0]     a_q, b_q;
  logic [CHUNK-1:0]  a_ch [NCHUNK];
  logic [CHUNK-1:0]  b_ch [NCHUNK];
  logic              sgn;
  logic              eq, gt, lt, last;

  // Flipping the sign bit maps two's-complement order onto unsigned order;
  // padding goes above the (possibly flipped) MSB.
  function automatic logic [PW-1:0] to_offset(input logic [WIDTH-1:0] v, input logic s);
    logic [WIDTH-1:0] t;
    t            = v;
    t[WIDTH-1]   = v[WIDTH-1] ^ s;
    return PW'(t);
  endfunction

`ifdef COMPARATOR_SIGNED_EN
  assign sgn = signed_mode;
`else
  assign sgn = 1'b0;
`endif

  for (genvar g = 0; g < NCHUNK; g++) begin : g_slice
    assign a_ch[g] = a_q[g*CHUNK +: CHUNK];
    assign b_ch[g] = b_q[g*CHUNK +: CHUNK];
  end

  chunk_compare #(.CHUNK(CHUNK)) u_cmp (
    .a  (a_ch[idx]),
    .b  (b_ch[idx]),
    .eq (eq),
    .gt (gt),
    .lt (lt)
  );

  assign last = gt || lt || (eq && (idx == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand capture: data only, no reset needed since reset returns to IDLE.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_q <= to_offset(bit1, sgn);
      b_q <= to_offset(bit2, sgn);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      final_answer <= 3'b000;
      chunks_used  <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) idx <= IDXW'(NCHUNK - 1);
        BUSY: begin
          if (last) begin
            final_answer <= gt ? CMP_GT : (lt ? CMP_LT : CMP_EQ);
            chunks_used  <= CUW'(NCHUNK) - CUW'(idx);
          end else begin
            idx <= idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
